// File: rtl/redirect_ctrl_pkg.sv
// Shared types and default pipeline stage indices for the redirect controller.
package redirect_ctrl_pkg;

  // Redirect handshake state: nothing outstanding, or one redirect awaiting IF.
  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } state_e;

  // Default stage indices of the 5-stage pipeline.
  localparam int unsigned STG_IF  = 0;
  localparam int unsigned STG_ID  = 1;
  localparam int unsigned STG_EX  = 2;
  localparam int unsigned STG_MEM = 3;
  localparam int unsigned STG_WB  = 4;

  // Index width able to address n sources (never below 1 bit).
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter with synchronous clear that dominates increment.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] value
);

  logic [W-1:0] r_value;
  logic         w_at_max;

  assign w_at_max = &r_value;
  assign value    = r_value;

  // Count up on inc, hold at all-ones, clear wins over a same-cycle increment.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_value <= '0;
    end else if (clr) begin
      r_value <= '0;
    end else if (inc && !w_at_max) begin
      r_value <= r_value + W'(1);
    end
  end

endmodule

// File: rtl/redirect_ctrl.sv
// Arbitrates pipeline redirect sources, drives the IF redirect handshake and
// per-stage flush mask, and counts accepted redirects per source.
module redirect_ctrl
  import redirect_ctrl_pkg::*;
#(
  parameter int unsigned NUM_STAGES           = 5,
  parameter int unsigned NUM_SRC              = 3,
  parameter int unsigned SRC_STAGE [NUM_SRC]  = '{STG_WB, STG_EX, STG_IF},
  parameter int unsigned XLEN                 = 32,
  parameter int unsigned CNT_W                = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_SRC-1:0]             src_valid,
  input  logic [NUM_SRC-1:0][XLEN-1:0]   src_addr,
  output logic                           redir_valid,
  input  logic                           redir_ready,
  output logic [XLEN-1:0]                redir_addr,
  output logic [NUM_STAGES-1:0]          flush,
  input  logic                           cnt_clr,
  output logic [NUM_SRC-1:0][CNT_W-1:0]  redir_cnt
);

  localparam int unsigned IDX_W = idx_width(NUM_SRC);

  state_e                 r_state;
  logic [IDX_W-1:0]       r_idx;
  logic [XLEN-1:0]        r_addr;

  logic                   w_win_vld;
  logic [IDX_W-1:0]       w_win_idx;
  logic [XLEN-1:0]        w_win_addr;
  logic                   w_take_new;
  logic                   w_sel_vld;
  logic [IDX_W-1:0]       w_sel_idx;
  logic [XLEN-1:0]        w_sel_addr;
  logic [NUM_STAGES-1:0]  w_mask;
  logic                   w_hs;
  logic [NUM_SRC-1:0]     w_inc;

  // Fixed-priority encoder: lowest-index valid source wins.
  always_comb begin
    w_win_vld  = 1'b0;
    w_win_idx  = '0;
    w_win_addr = '0;
    for (int i = int'(NUM_SRC) - 1; i >= 0; i--) begin
      if (src_valid[i]) begin
        w_win_vld  = 1'b1;
        w_win_idx  = IDX_W'(i);
        w_win_addr = src_addr[i];
      end
    end
  end

  // A new winner is shown in IDLE, or in PEND only if it outranks the latched source.
  assign w_take_new = w_win_vld && ((r_state == IDLE) || (w_win_idx < r_idx));
  assign w_sel_vld  = (r_state == PEND) || w_win_vld;
  assign w_sel_idx  = w_take_new ? w_win_idx  : r_idx;
  assign w_sel_addr = w_take_new ? w_win_addr : r_addr;

  // Flush mask of the shown source: kill every stage younger than the source's stage.
  always_comb begin
    w_mask = '0;
    for (int unsigned s = 0; s < NUM_SRC; s++) begin
      if (w_sel_idx == IDX_W'(s)) begin
        for (int unsigned k = 0; k < NUM_STAGES; k++) begin
          w_mask[k] = (k < SRC_STAGE[s]);
        end
      end
    end
  end

  // Outputs are forced quiet while reset is held low.
  assign redir_valid = reset && w_sel_vld;
  assign redir_addr  = redir_valid ? w_sel_addr : '0;
  assign flush       = redir_valid ? w_mask : '0;
  assign w_hs        = redir_valid && redir_ready;

  // Credit the accepted redirect to the source shown in the handshake cycle.
  always_comb begin
    w_inc = '0;
    for (int unsigned s = 0; s < NUM_SRC; s++) begin
      w_inc[s] = w_hs && (w_sel_idx == IDX_W'(s));
    end
  end

  // Handshake FSM with single-entry latch for a redirect IF has not yet taken.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_addr  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_win_vld && !redir_ready) begin
            r_state <= PEND;
            r_idx   <= w_win_idx;
            r_addr  <= w_win_addr;
          end
        end
        PEND: begin
          if (redir_ready) begin
            r_state <= IDLE;
          end else if (w_take_new) begin
            r_idx   <= w_win_idx;
            r_addr  <= w_win_addr;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // One saturating counter per redirect source.
  for (genvar g = 0; g < NUM_SRC; g++) begin : g_cnt
    sat_counter #(
      .W (CNT_W)
    ) u_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (w_inc[g]),
      .clr   (cnt_clr),
      .value (redir_cnt[g])
    );
  end

endmodule

// File: tb/tb_redirect_ctrl.sv
// Scoreboard bench for redirect_ctrl: driver pushes model expectations, monitor compares.
module tb_redirect_ctrl;

  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic             clk;
  logic             reset;
  logic [2:0]       src_valid;
  logic [2:0][31:0] src_addr;
  logic             redir_valid;
  logic             redir_ready;
  logic [31:0]      redir_addr;
  logic [4:0]       flush;
  logic             cnt_clr;
  logic [2:0][CW-1:0] redir_cnt;

  typedef struct packed {
    logic              v;
    logic [31:0]       a;
    logic [4:0]        f;
    logic [2:0][CW-1:0] c;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state: which source is outstanding (-1 = none) and counts.
  int          stage_of[3] = '{4, 2, 0};
  int          m_pend = -1;
  logic [31:0] m_paddr = '0;
  int          m_cnt[3] = '{0, 0, 0};

  redirect_ctrl #(
    .CNT_W (CW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .src_valid   (src_valid),
    .src_addr    (src_addr),
    .redir_valid (redir_valid),
    .redir_ready (redir_ready),
    .redir_addr  (redir_addr),
    .flush       (flush),
    .cnt_clr     (cnt_clr),
    .redir_cnt   (redir_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  function automatic logic [2:0][31:0] mk(input logic [31:0] a0, input logic [31:0] a1,
                                          input logic [31:0] a2);
    logic [2:0][31:0] r;
    r[0] = a0; r[1] = a1; r[2] = a2;
    return r;
  endfunction

  // Drive one cycle of inputs, predict this cycle's outputs, advance the model.
  task automatic step(input logic rst, input logic [2:0] sv, input logic [2:0][31:0] ad,
                      input logic rdy, input logic clr);
    exp_t        e;
    int          win;
    int          shown;
    logic [31:0] sa;
    @(negedge clk);
    reset = rst; src_valid = sv; src_addr = ad; redir_ready = rdy; cnt_clr = clr;
    e = '0;
    if (!rst) begin
      m_pend = -1;
      for (int i = 0; i < 3; i++) m_cnt[i] = 0;
    end else begin
      win = -1;
      for (int i = 2; i >= 0; i--) if (sv[i]) win = i;
      shown = win;
      sa = (win >= 0) ? ad[win] : 32'h0;
      if (m_pend >= 0 && !(win >= 0 && win < m_pend)) begin
        shown = m_pend;
        sa = m_paddr;
      end
      if (shown >= 0) begin
        e.v = 1'b1;
        e.a = sa;
        e.f = 5'((1 << stage_of[shown]) - 1);
      end
    end
    for (int i = 0; i < 3; i++) e.c[i] = CW'(m_cnt[i]);
    if (rst) begin
      if (e.v && rdy) begin
        m_pend = -1;
        if (m_cnt[shown] < CMAX) m_cnt[shown]++;
      end else if (e.v) begin
        m_pend = shown;
        m_paddr = sa;
      end
      if (clr) for (int i = 0; i < 3; i++) m_cnt[i] = 0;
    end
    exp_q.push_back(e);
  endtask

  // Monitor: compare DUT outputs against the queued expectation each cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("redir_valid", 32'(redir_valid), 32'(e.v));
        chk("redir_addr", redir_addr, e.a);
        chk("flush", 32'(flush), 32'(e.f));
        for (int i = 0; i < 3; i++) chk($sformatf("redir_cnt%0d", i), 32'(redir_cnt[i]), 32'(e.c[i]));
      end
    end
  end

  initial begin
    logic [2:0][31:0] z;
    z = mk(0, 0, 0);
    reset = 1'b0; src_valid = '0; src_addr = z; redir_ready = 1'b0; cnt_clr = 1'b0;
    // Reset, with a request visible to confirm outputs stay quiet.
    step(0, 3'b111, mk(1, 2, 3), 1, 0);
    step(0, 3'b000, z, 0, 0);
    // Single mid-priority request accepted in its arrival cycle.
    step(1, 3'b010, mk(0, 32'h100, 0), 1, 0);
    step(1, 3'b000, z, 0, 0);
    // Two sources together: src0 wins.
    step(1, 3'b011, mk(32'h80, 32'h100, 0), 1, 0);
    step(1, 3'b000, z, 0, 0);
    // Held request while IF stalls for three cycles.
    repeat (3) step(1, 3'b010, mk(0, 32'h200, 0), 0, 0);
    step(1, 3'b010, mk(0, 32'h200, 0), 1, 0);
    step(1, 3'b000, z, 0, 0);
    // Pending src1 preempted by src0; src2 during pending is ignored.
    step(1, 3'b010, mk(0, 32'h300, 0), 0, 0);
    step(1, 3'b101, mk(32'h80, 0, 32'h400), 0, 0);
    step(1, 3'b100, mk(0, 0, 32'h500), 0, 0);
    step(1, 3'b000, z, 1, 0);
    step(1, 3'b000, z, 0, 0);
    // Saturation of the src2 counter, then clear against a simultaneous request.
    for (int i = 0; i < 20; i++) step(1, 3'b100, mk(0, 0, 32'h40 + 32'(i)), 1, 0);
    step(1, 3'b000, z, 0, 0);
    step(1, 3'b100, mk(0, 0, 32'h44), 1, 1);
    step(1, 3'b000, z, 0, 0);
    // Reset during a pending redirect discards it.
    step(1, 3'b010, mk(0, 32'h600, 0), 0, 0);
    step(0, 3'b010, mk(0, 32'h600, 0), 0, 0);
    step(0, 3'b000, z, 1, 0);
    step(1, 3'b000, z, 1, 0);
    step(1, 3'b000, z, 0, 0);
    // Randomized traffic.
    for (int n = 0; n < 2000; n++) begin
      step(($urandom_range(0, 99) != 0), 3'($urandom_range(0, 7)),
           mk($urandom, $urandom, $urandom), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 39) == 0));
    end
    step(1, 3'b000, z, 0, 0);
    @(negedge clk);
    #5;
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d expected 0 entries left", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/redirect_ctrl.md
REDIRECT_CTRL -- requirements
Module: redirect_ctrl

Interface
REQ-001 SHALL have parameter NUM_STAGES, default 5, pipeline stage count (stage 0 = IF, stage NUM_STAGES-1 = WB).
REQ-002 SHALL have parameter NUM_SRC, default 3, redirect source count (index 0 = highest priority).
REQ-003 SHALL have parameter SRC_STAGE, default {4,2,0} (src0 = WB trap, src1 = EX mispredict, src2 = IF prediction), stage index of each source.
REQ-004 SHALL have parameter XLEN, default 32, address width.
REQ-005 SHALL have parameter CNT_W, default 16, event counter width.
REQ-006 clk  in  1  clock, all state on rising edge.
REQ-007 reset  in  1  asynchronous, active-low reset.
REQ-008 src_valid  in  NUM_SRC  redirect request per source.
REQ-009 src_addr  in  NUM_SRC x XLEN  target address per source.
REQ-010 redir_valid  out  1  redirect offered to IF.
REQ-011 redir_ready  in  1  IF accepts redirect.
REQ-012 redir_addr  out  XLEN  redirect target.
REQ-013 flush  out  NUM_STAGES  per-stage flush; bit k kills stage k contents.
REQ-014 cnt_clr  in  1  synchronous clear of all event counters.
REQ-015 redir_cnt  out  NUM_SRC x CNT_W  accepted redirects per source.

Function
REQ-016 Winner SHALL be the lowest index i with src_valid[i]=1; combinational, same cycle.
REQ-017 Flush mask for source i SHALL set bits 0..SRC_STAGE[i]-1 and clear all others; SRC_STAGE[i]=0 gives an empty mask.
REQ-018 FSM SHALL have states IDLE and PEND.
REQ-019 IDLE: redir_valid=winner present, redir_addr=src_addr[winner], flush=mask(winner).
REQ-020 IDLE, winner present and redir_ready=0: next state PEND, latch winner index and address.
REQ-021 IDLE, redir_ready=1: handshake completes, state stays IDLE, redir_cnt[winner] increments.
REQ-022 PEND: redir_valid=1; redir_addr and flush come from the latched source, unless REQ-023 applies.
REQ-023 PEND, new winner j < latched p: j replaces p the same cycle in outputs and in the latch; p is dropped, not counted.
REQ-024 PEND, new winner j >= latched p: j ignored (wrong path); no latch change, no count.
REQ-025 PEND, redir_ready=1: handshake completes for the source shown that cycle; next state IDLE; that source's counter increments.
REQ-026 Redirects SHALL NOT queue; at most one redirect is outstanding.
REQ-027 redir_cnt SHALL saturate at 2^CNT_W-1.
REQ-028 cnt_clr SHALL zero all counters; it wins over a same-cycle increment.
REQ-029 Handshake latency SHALL be 0 cycles: a request with redir_ready=1 completes in its arrival cycle.

Reset
REQ-030 Reset low SHALL asynchronously force state IDLE, latch index 0, latch address 0, and all redir_cnt 0.
REQ-031 While reset is low, redir_valid=0, redir_addr=0, flush=0, regardless of src_valid.
REQ-032 Reset asserted in PEND SHALL discard the pending redirect; no handshake completes.
REQ-033 After deassertion, operation SHALL start from IDLE on the next rising edge.

Structure
REQ-034 Shared package SHALL hold the FSM state enum (IDLE, PEND) and the default stage-index constants (STG_IF=0, STG_ID=1, STG_EX=2, STG_MEM=3, STG_WB=4).
REQ-035 The event counter SHALL be a sub-module, sat_counter (width param, inc, clr, value), instantiated NUM_SRC times.
REQ-036 The priority encoder and mask generation SHALL be combinational logic inside redirect_ctrl.

Verification
REQ-037 IDLE; src_valid=3'b010, addr1=0x100, redir_ready=1 -> redir_valid=1, redir_addr=0x100, flush=5'b00011 same cycle; redir_cnt[1]=1.
REQ-038 src0 (addr 0x80) and src1 (addr 0x100) both valid, redir_ready=1 -> redir_addr=0x80, flush=5'b01111; only redir_cnt[0] increments.
REQ-039 src1 addr 0x200, redir_ready=0 for 3 cycles, then 1 -> redir_valid/0x200/flush=5'b00011 held 4 cycles, then IDLE, redir_cnt[1]=1.
REQ-040 PEND on src1, src0 arrives with 0x80 and redir_ready=0 -> redir_addr=0x80, flush=5'b01111 immediately; on ready only redir_cnt[0] increments; src2 arriving during PEND ignored.
REQ-041 CNT_W=4; 20 accepted src2 redirects -> redir_cnt[2]=15 and flush stays 0; cnt_clr with a simultaneous request -> counter 0.
REQ-042 Reset low during PEND -> outputs 0 asynchronously; after release with src_valid=0 -> redir_valid=0, all counters 0.
